sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl_if.sv | 40 ++++
 rtl/sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_ctrl_if.sv
// Bundle of the sweep_ctrl control and status signals.
// Optional feature macro: SWEEP_HOLD_EN adds the hold (freeze) request.
//
// Handshake: start and stop are level-sampled strobes, not valid/ready
// pairs. start is looked at only while the controller is idle and is
// accepted on the rising edge where it is seen. stop is looked at only
// while a sweep is running. lo/hi only need to be stable on the edge
// that accepts start. done and err are single-cycle status pulses and
// carry no back-pressure.
interface sweep_ctrl_if;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
`ifdef SWEEP_HOLD_EN
  logic       hold;
`endif
  logic [3:0] Q;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] state;   // FSM state for debug/observation

  modport master (
`ifdef SWEEP_HOLD_EN
    output hold,
`endif
    output start, stop, lo, hi,
    input  Q, dir, busy, done, err, state
  );

  modport slave (
`ifdef SWEEP_HOLD_EN
    input  hold,
`endif
    input  start, stop, lo, hi,
    output Q, dir, busy, done, err, state
  );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: bounded up/down sweep counter.
// A run counts Q from lo up to hi and back down to lo, NUM_SWEEPS times,
// then pulses done. lo > hi is rejected with a one-cycle err pulse.
// stop aborts a run and holds Q. All outputs are registered.
// Optional feature macro: SWEEP_HOLD_EN (hold input freezes a running sweep).
module sweep_ctrl #(
  parameter int NUM_SWEEPS = 2   // full lo->hi->lo sweeps per run, 1..15
) (
  input  logic         Clock,
  input  logic         reset,  // asynchronous, active low
  sweep_ctrl_if.slave  bus
);

  localparam logic [3:0] LP_NUM_SWEEPS = 4'(NUM_SWEEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_q;
  logic [3:0] r_lo;
  logic [3:0] r_hi;
  logic [3:0] r_cnt;
  logic       r_dir;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  logic       w_start;
  logic       w_stop;
  logic [3:0] w_lo;
  logic [3:0] w_hi;
  logic       w_hold;
  logic [3:0] w_cnt_inc;

  assign w_start   = bus.start;
  assign w_stop    = bus.stop;
  assign w_lo      = bus.lo;
  assign w_hi      = bus.hi;
  assign w_cnt_inc = r_cnt + 4'd1;

`ifdef SWEEP_HOLD_EN
  assign w_hold = bus.hold;
`else
  // Without the hold feature a running sweep never freezes.
  assign w_hold = 1'b0;
`endif

  // FSM: state, counter, latched limits and all registered outputs.
  // Stop is tested first in UP/DOWN so it wins over hold and counting.
  // Q only moves toward the far limit while strictly inside the range,
  // which keeps it inside [lo, hi] with no 4-bit wrap.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_q     <= 4'd0;
      r_lo    <= 4'd0;
      r_hi    <= 4'd0;
      r_cnt   <= 4'd0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // done and err are pulses; they are re-asserted only where needed
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_lo < w_hi) begin
              r_lo    <= w_lo;
              r_hi    <= w_hi;
              r_q     <= w_lo;
              r_cnt   <= 4'd0;
              r_state <= S_UP;
              r_dir   <= 1'b1;
              r_busy  <= 1'b1;
            end else if (w_lo == w_hi) begin
              // degenerate range: nothing to sweep, complete at once
              r_lo    <= w_lo;
              r_hi    <= w_hi;
              r_q     <= w_lo;
              r_cnt   <= 4'd0;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              // lo > hi: reject, Q and limits untouched
              r_err <= 1'b1;
            end
          end
        end

        S_UP: begin
          if (w_stop) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!w_hold) begin
            if (r_q != r_hi) begin
              r_q <= r_q + 4'd1;
            end else begin
              // turn around at the top; lo < hi so hi-1 is still in range
              r_q     <= r_q - 4'd1;
              r_state <= S_DOWN;
              r_dir   <= 1'b0;
            end
          end
        end

        S_DOWN: begin
          if (w_stop) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!w_hold) begin
            if (r_q != r_lo) begin
              r_q <= r_q - 4'd1;
            end else begin
              // bottom reached: one full sweep completed
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == LP_NUM_SWEEPS) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_q     <= r_q + 4'd1;
                r_state <= S_UP;
                r_dir   <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          // done was raised on entry; leave after exactly one cycle
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_dir   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q     = r_q;
  assign bus.dir   = r_dir;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.state = r_state;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl. Two instances (NUM_SWEEPS=1 and 2) share
// one set of stimulus; each check names the instance it looks at.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sweep_ctrl;

  logic       Clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       hold;

  int n_checks = 0;
  int n_fail   = 0;

  sweep_ctrl_if u_if1 ();
  sweep_ctrl_if u_if2 ();

  assign u_if1.start = start;
  assign u_if1.stop  = stop;
  assign u_if1.lo    = lo;
  assign u_if1.hi    = hi;
  assign u_if2.start = start;
  assign u_if2.stop  = stop;
  assign u_if2.lo    = lo;
  assign u_if2.hi    = hi;
`ifdef SWEEP_HOLD_EN
  assign u_if1.hold  = hold;
  assign u_if2.hold  = hold;
`endif

  sweep_ctrl #(.NUM_SWEEPS(1)) u_dut1 (
    .Clock (Clock),
    .reset (reset),
    .bus   (u_if1.slave)
  );

  sweep_ctrl #(.NUM_SWEEPS(2)) u_dut2 (
    .Clock (Clock),
    .reset (reset),
    .bus   (u_if2.slave)
  );

  // clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge, return on the following falling edge
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin : main
    int exp_q[7]   = '{2, 3, 4, 5, 4, 3, 2};
    int exp_dir[7] = '{1, 1, 1, 1, 0, 0, 0};
    int prev_q;
    int changes;
    int hits15;
    int hits0;
    int wraps;
    bit saw_done;

    reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    lo    = 4'd0;
    hi    = 4'd0;
    hold  = 1'b0;

    // ---------------- reset state
    #12;
    check("rst_q",    int'(u_if1.Q),    0);
    check("rst_busy", int'(u_if1.busy), 0);
    check("rst_dir",  int'(u_if1.dir),  0);
    check("rst_done", int'(u_if2.done), 0);
    check("rst_err",  int'(u_if2.err),  0);
    @(negedge Clock);
    reset = 1'b1;
    tick();

    // ---------------- single sweep 2..5 on NUM_SWEEPS=1
    lo = 4'd2; hi = 4'd5; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) begin
        start = 1'b0;
        lo = 4'd0; hi = 4'd15;   // must not affect the running sweep
      end
      check($sformatf("s1_q%0d", i),   int'(u_if1.Q),   exp_q[i]);
      check($sformatf("s1_dir%0d", i), int'(u_if1.dir), exp_dir[i]);
      check($sformatf("s1_busy%0d", i), int'(u_if1.busy), 1);
      check($sformatf("s1_done%0d", i), int'(u_if1.done), 0);
    end
    tick();
    check("s1_done_pulse", int'(u_if1.done), 1);
    check("s1_done_q",     int'(u_if1.Q),    2);
    check("s1_done_busy",  int'(u_if1.busy), 0);
    tick();
    check("s1_done_clr", int'(u_if1.done),  0);
    check("s1_idle",     int'(u_if1.state), 0);
    // park the NUM_SWEEPS=2 instance, which is still running
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("park_busy2", int'(u_if2.busy), 0);

    // ---------------- full range 0..15, two sweeps, NUM_SWEEPS=2
    lo = 4'd0; hi = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    check("s2_first_q", int'(u_if2.Q), 0);
    prev_q   = int'(u_if2.Q);
    changes  = 0;
    hits15   = 0;
    hits0    = 1;
    wraps    = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (u_if2.done) begin
        saw_done = 1'b1;
        break;
      end
      if (int'(u_if2.Q) != prev_q) begin
        changes++;
        if (u_if2.Q == 4'd15) hits15++;
        if (u_if2.Q == 4'd0)  hits0++;
        if (int'(u_if2.Q) - prev_q != 1 && prev_q - int'(u_if2.Q) != 1) wraps++;
        prev_q = int'(u_if2.Q);
      end
    end
    check("s2_done_seen", int'(saw_done), 1);
    check("s2_changes",   changes, 60);
    check("s2_hits15",    hits15, 2);
    check("s2_hits0",     hits0, 3);
    check("s2_wraps",     wraps, 0);
    check("s2_end_q",     int'(u_if2.Q), 0);
    tick();
    check("s2_idle_done", int'(u_if2.done), 0);
    // dut1 also ran 0..15 once and finished earlier at Q=0
    check("s2_dut1_q", int'(u_if1.Q), 0);

    // ---------------- rejected start (lo > hi)
    lo = 4'd9; hi = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", int'(u_if1.err),  1);
    check("err_busy",  int'(u_if1.busy), 0);
    check("err_q",     int'(u_if1.Q),    0);
    check("err_state", int'(u_if1.state), 0);
    tick();
    check("err_clr", int'(u_if1.err), 0);

    // ---------------- degenerate range lo == hi
    lo = 4'd7; hi = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("eq_q",    int'(u_if2.Q),    7);
    check("eq_done", int'(u_if2.done), 1);
    check("eq_busy", int'(u_if2.busy), 0);
    check("eq_err",  int'(u_if2.err),  0);
    tick();
    check("eq_done_clr", int'(u_if2.done), 0);
    check("eq_q_hold",   int'(u_if2.Q),    7);

    // ---------------- stop at Q=4 with start held high
    lo = 4'd1; hi = 4'd10; start = 1'b1;
    for (int i = 0; i < 4; i++) tick();   // Q: 1,2,3,4
    check("stop_pre_q", int'(u_if1.Q), 4);
    check("stop_pre_dir", int'(u_if1.dir), 1);
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("stop_q",     int'(u_if1.Q),    4);
    check("stop_busy",  int'(u_if1.busy), 0);
    check("stop_dir",   int'(u_if1.dir),  0);
    check("stop_done",  int'(u_if1.done), 0);
    check("stop_err",   int'(u_if1.err),  0);
    tick();
    check("stop_idle_q", int'(u_if1.Q), 4);
    check("stop_done2",  int'(u_if1.done), 0);

    // ---------------- asynchronous reset mid-DOWN
    lo = 4'd2; hi = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();   // Q: 3,4,5,4 (now DOWN)
    check("arst_pre_q",   int'(u_if1.Q),   4);
    check("arst_pre_dir", int'(u_if1.dir), 0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_q",     int'(u_if1.Q),     0);
    check("arst_busy",  int'(u_if1.busy),  0);
    check("arst_state", int'(u_if1.state), 0);
    check("arst_q2",    int'(u_if2.Q),     0);
    @(negedge Clock);
    reset = 1'b1;
    lo = 4'd3; hi = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_q",    int'(u_if1.Q),    3);
    check("post_rst_busy", int'(u_if1.busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

`ifdef SWEEP_HOLD_EN
    // ---------------- hold freezes a running sweep
    lo = 4'd0; hi = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();   // Q: 1,2,3
    check("hold_pre_q", int'(u_if1.Q), 3);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_q%0d", i),    int'(u_if1.Q),    3);
      check($sformatf("hold_busy%0d", i), int'(u_if1.busy), 1);
      check($sformatf("hold_dir%0d", i),  int'(u_if1.dir),  1);
    end
    hold = 1'b0;
    tick();
    check("hold_resume_q", int'(u_if1.Q), 4);
    // stop still wins while held
    hold = 1'b1;
    stop = 1'b1;
    tick();
    hold = 1'b0;
    stop = 1'b0;
    check("hold_stop_busy", int'(u_if1.busy), 0);
    check("hold_stop_q",    int'(u_if1.Q),    4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
